// File: rtl/inbuffer_collect.sv
// inbuffer_collect: deserializing input stage of the DCT datapath.
// Collects arrsize float words {sign, exp[E], mant[M]} from a valid/ready
// source into one flat frame. The completed frame is held stable, with the
// source back-pressured, until the DCT core acknowledges it.
// Optional build macro DENORM_FLUSH_EN: when defined, denormal words
// (exp==0, mant!=0) are stored as signed zero. Otherwise words are stored bit-exact.
module inbuffer_collect #(
  parameter int M       = 23,
  parameter int E       = 8,
  parameter int arrsize = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [M+E:0]                      in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              clr,
  output logic [arrsize*(M+E+1)-1:0]        out_arr,
  output logic                              out_valid,
  input  logic                              out_ack,
  output logic [$clog2(arrsize)-1:0]        fill_cnt
);

  localparam int W  = M + E + 1;
  localparam int CW = $clog2(arrsize);
  localparam logic [CW-1:0] LAST = CW'(arrsize - 1);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   slot_q [arrsize];
  logic           wr_en;
  logic [W-1:0]   wr_word;

  // Word conditioning applied at capture; no other arithmetic touches the data.
  function automatic logic [W-1:0] condition_word(input logic [W-1:0] w);
`ifdef DENORM_FLUSH_EN
    if ((w[M+E-1:M] == '0) && (w[M-1:0] != '0))
      return {w[W-1], {(E+M){1'b0}}};
    else
      return w;
`else
    return w;
`endif
  endfunction

  assign wr_word = condition_word(in_data);

  // Next-state decode: clr beats a same-cycle accept in FILL; in HOLD only
  // out_ack matters, so clr there is ignored and can never drop a frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    case (state_q)
      FILL: begin
        if (clr) begin
          cnt_d = '0;
        end else if (in_valid) begin
          wr_en = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ack) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Control registers: handshake state and fill position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame storage: only the addressed slot changes; untouched slots keep old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < arrsize; i++) slot_q[i] <= '0;
    end else if (wr_en) begin
      slot_q[cnt_q] <= wr_word;
    end
  end

  for (genvar g = 0; g < arrsize; g++) begin : g_pack
    assign out_arr[g*W +: W] = slot_q[g];
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign fill_cnt  = cnt_q;

endmodule

// File: tb/tb_inbuffer_collect.sv
// Bench for inbuffer_collect: directed scenarios plus randomized traffic,
// checked against a frame-level reference model.
module tb_inbuffer_collect;

  localparam int W = 32;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic           clr;
  logic [N*W-1:0] out_arr;
  logic           out_valid;
  logic           out_ack;
  logic [3:0]     fill_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: frame contents, words captured in the current frame,
  // and whether a completed frame is waiting for acknowledgement.
  logic [W-1:0] m_slot [N];
  logic [W-1:0] m_frame [$];
  bit           m_hold;

  inbuffer_collect dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clr(clr), .out_arr(out_arr), .out_valid(out_valid),
    .out_ack(out_ack), .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] m_store(input logic [W-1:0] d);
`ifdef DENORM_FLUSH_EN
    if (((d >> 23) & 32'hFF) == 0 && (d & 32'h007F_FFFF) != 0) return d & 32'h8000_0000;
`endif
    return d;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < N; k++) m_slot[k] = '0;
    m_frame.delete();
    m_hold = 0;
  endtask

  task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N*W-1:0] ea;
    for (int k = 0; k < N; k++) ea[k*W +: W] = m_slot[k];
    check({tag, ".in_ready"},  N*W'(in_ready),  N*W'(!m_hold));
    check({tag, ".out_valid"}, N*W'(out_valid), N*W'(m_hold));
    check({tag, ".fill_cnt"},  N*W'(fill_cnt),  N*W'(m_frame.size()));
    check({tag, ".out_arr"},   out_arr, ea);
  endtask

  // One clock cycle: apply inputs, advance the model by the frame rules,
  // then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic c, input logic a);
    in_valid = v; in_data = d; clr = c; out_ack = a;
    if (!m_hold) begin
      if (c) begin
        m_frame.delete();
      end else if (v) begin
        m_slot[m_frame.size()] = m_store(d);
        m_frame.push_back(d);
        if (m_frame.size() == N) begin
          m_frame.delete();
          m_hold = 1;
        end
      end
    end else if (a) begin
      m_hold = 0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    w = $urandom;
    if ($urandom_range(0, 3) == 0) w = w & 32'h807F_FFFF;
    return w;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 0; in_data = '0; clr = 0; out_ack = 0;
    m_reset();
    #1;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("post_reset");

    // 1: back-to-back frame, no acknowledgement
    for (int k = 0; k < N; k++) begin
      step(1'b1, 32'h3F80_0000 + k, 1'b0, 1'b0);
      check_all("t1_fill");
    end
    for (int k = 0; k < N; k++)
      check($sformatf("t1_slot%0d", k), N*W'(out_arr[k*W +: W]), N*W'(32'h3F80_0000 + k));
    check("t1_in_ready_const", N*W'(in_ready), '0);

    // 2: hold with source pushing (and clr) ignored, then ack with in_valid high
    for (int k = 0; k < 5; k++) begin
      step(1'b1, $urandom, 1'(k & 1), 1'b0);
      check_all("t2_hold");
    end
    step(1'b1, 32'h1234_5678, 1'b0, 1'b1);
    check_all("t2_ack");
    check("t2_fill_cnt_zero", N*W'(fill_cnt), '0);

    // 3: gapped input
    for (int k = 0; k < 2*N; k++) begin
      step(1'(k % 2 == 0), rand_word(), 1'b0, 1'($urandom_range(0, 1)));
      check_all("t3_gap");
    end
    check("t3_complete", N*W'(out_valid), N*W'(1));
    step(1'b0, '0, 1'b1, 1'b1);
    check_all("t3_clr_ack");

    // 4: partial frame discarded by clr, then a clean frame
    for (int k = 0; k < 7; k++) step(1'b1, rand_word(), 1'b0, 1'b0);
    check_all("t4_partial");
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check_all("t4_clr");
    check("t4_cnt_zero", N*W'(fill_cnt), '0);
    for (int k = 0; k < N; k++) step(1'b1, 32'h4000_0000 + k, 1'b0, 1'b0);
    check_all("t4_frame");
    check("t4_slot7", N*W'(out_arr[7*W +: W]), N*W'(32'h4000_0007));
    step(1'b0, '0, 1'b0, 1'b1);

    // 5: asynchronous reset mid-fill
    for (int k = 0; k < 9; k++) step(1'b1, rand_word(), 1'b0, 1'b0);
    check_all("t5_pre");
    in_valid = 0;
    #3 rst = 1'b1;
    m_reset();
    #1;
    check_all("t5_async_rst");
    check("t5_arr_zero", out_arr, '0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_all("t5_after");

    // 6: denormal in slot 3
    for (int k = 0; k < N; k++)
      step(1'b1, (k == 3) ? 32'h8000_0001 : 32'h3F00_0000 + k, 1'b0, 1'b0);
    check_all("t6_frame");
`ifdef DENORM_FLUSH_EN
    check("t6_slot3", N*W'(out_arr[3*W +: W]), N*W'(32'h8000_0000));
`else
    check("t6_slot3", N*W'(out_arr[3*W +: W]), N*W'(32'h8000_0001));
`endif
    step(1'b0, '0, 1'b0, 1'b1);
    check_all("t6_ack");

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 3) != 0), rand_word(),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) == 0));
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
